// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's access handshake and data bus toward the RAM arbiter
interface ram_arbiter_if;
  logic req;
  logic we;
  logic lock;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic gnt;
  logic ack;
  logic [31:0] rdata;
  modport master (output req, we, lock, addr, wdata, input gnt, ack, rdata);
  modport slave (input req, we, lock, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter with bounded lock for a single-port data RAM
module ram_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  ram_arbiter_if.slave m0,
  ram_arbiter_if.slave m1,
  output logic        ram_we,
  output logic        ram_re,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [7:0] lcnt_q, lcnt_d, lcnt_inc;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic g0, g1, we_sel, lock_x, rel;
  always_comb begin
    g0 = state_q == LOCK0 ? m0.req : state_q == LOCK1 ? 1'b0 : m0.req & (~m1.req | last_q);
    g1 = state_q == LOCK1 ? m1.req : state_q == LOCK0 ? 1'b0 : m1.req & (~m0.req | ~last_q);
    we_sel = g0 ? m0.we : g1 ? m1.we : 1'b0;
    ram_we = we_sel & ~reset;
    ram_re = (g0 | g1) & ~we_sel;
    ram_addr = g0 ? m0.addr : g1 ? m1.addr : 14'd0;
    ram_wdata = g0 ? m0.wdata : g1 ? m1.wdata : 32'd0;
    lock_x = state_q == LOCK1 ? m1.lock : m0.lock;
    lcnt_inc = lcnt_q + 8'd1;
    rel = ~lock_x | (lcnt_inc == 8'(LOCK_MAX));
    state_d = state_q == IDLE ? (g0 & m0.lock ? LOCK0 : g1 & m1.lock ? LOCK1 : IDLE)
                              : (rel ? IDLE : state_q);
    lcnt_d = state_d == IDLE ? 8'd0 : state_q == IDLE ? 8'd1 : lcnt_inc;
    last_d = g0 ? 1'b0 : g1 ? 1'b1 : state_q == LOCK0 ? 1'b0 : state_q == LOCK1 ? 1'b1 : last_q;
    ack0_d = g0;
    ack1_d = g1;
    rdata0_d = g0 & ~m0.we ? ram_rdata : rdata0_q;
    rdata1_d = g1 & ~m1.we ? ram_rdata : rdata1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      lcnt_q <= 8'd0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      lcnt_q <= lcnt_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign m0.gnt = g0;
  assign m1.gnt = g1;
  assign m0.ack = ack0_q;
  assign m1.ack = ack1_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter for the single-port data RAM (4096 × 32-bit words, 14-bit byte address, combinational read, posedge write). It sits between the RAM and two requesters: M0 is the CPU memory stage, M1 is the debug/loader port. It grants at most one access per cycle using round-robin priority, and supports a bounded lock for atomic multi-access sequences. Read data and completion are returned one cycle after grant through a registered ack.

## Interface
- LOCK_MAX, 16: maximum consecutive cycles a master may hold the lock before it is forcibly released (range 2–255).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- mN_req  in  1  access request, N ∈ {0,1}.
- mN_we  in  1  1 = write, 0 = read.
- mN_lock  in  1  request to keep ownership after this access.
- mN_addr  in  14  byte address; bits [1:0] are ignored downstream.
- mN_wdata  in  32  write data.
- mN_gnt  out  1  combinational; the request is accepted this cycle.
- mN_ack  out  1  registered; high the cycle after mN_gnt.
- mN_rdata  out  32  registered read data; valid while mN_ack is high after a read.
- ram_we, ram_re  out  1  RAM write and read enables.
- ram_addr  out  14  address muxed from the granted master.
- ram_wdata  out  32  write data muxed from the granted master.
- ram_rdata  in  32  combinational RAM read data.

## Operation
- State machine states: IDLE, LOCK0, LOCK1. There is also a 1-bit round-robin pointer `last` (the last granted master) and a lock counter `lcnt` (8 bits).
- IDLE:
  - If only one master requests, it is granted.
  - If both request, the master ≠ `last` is granted.
  - `last` updates to the granted master.
- LOCKx: only Mx can be granted. A request from the other master stalls (gnt=0).
- Entry into LOCKx: Mx is granted with mx_lock=1. On entry, `lcnt` is set to 1.
- In LOCKx:
  - `lcnt` increments every cycle.
  - Return to IDLE when mx_lock=0 is sampled (regardless of req), or when `lcnt` reaches LOCK_MAX.
  - On a forced release, `last`=x, so the other master wins the next contention.
- The granted access drives RAM ports in the same cycle:
  - ram_re = gnt & ~we
  - ram_we = gnt & we
- With no grant, ram_we=ram_re=0 and ram_addr/ram_wdata are 0.
- At posedge after a grant:
  - mN_ack ← 1.
  - For a read, mN_rdata ← ram_rdata.
  - For a write, mN_rdata holds its previous value.
- Without a grant, mN_ack ← 0.
- Requesters hold req/we/addr/wdata stable until gnt. A req still high in the ack cycle is a new request (back-to-back allowed).
- gnt never depends on ack, so there is no combinational loop.

## Timing
- Reset values:
  - state IDLE, `last`=1 (M0 wins first contention), `lcnt`=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
- Reset mid-lock or mid-access: everything returns to reset values on the next posedge. A pending ack is dropped, and the RAM write in the reset cycle is suppressed (ram_we forced 0 while reset=1).
- Latency:
  - gnt is same-cycle.
  - ack and rdata arrive 1 cycle after gnt.
  - A single requester gets 1 access per cycle sustained.
- Contention: each master is guaranteed a grant within 2 cycles in IDLE, or within LOCK_MAX+1 cycles under the other master's lock.
- Same-address write (M0) then read (M1) in consecutive cycles: the read returns the new data.
- lock=1 with req=0 in IDLE: no effect.

## Test plan
- Reset, then m0 reads addr 0x0010 (RAM preloaded 0xDEADBEEF): m0_gnt same cycle; next cycle m0_ack=1, m0_rdata=0xDEADBEEF; m1_ack=0.
- Both request continuously for 6 cycles: grants alternate M0, M1, M0, M1, M0, M1; each ack follows its grant by one cycle.
- M1 writes 0x12345678 to 0x0020 with lock=1 for 3 cycles, then M1 lock=0, while M0 requests a read of 0x0020 throughout: M0 stalls until the lock drops, then reads 0x12345678.
- With LOCK_MAX=4, M1 holds lock=1 and req=1 forever while M0 requests: after 4 locked cycles M0 is granted, then the two alternate.
- Assert reset during LOCK0 with an outstanding write grant: no RAM write, all acks 0 the next cycle, and state IDLE (M0 wins the next contention).
